// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - SHA-256 round constants, IVs, FSM state type and round functions
package sha256_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, ROUND, ADD, DONE} state_e;

  localparam logic [255:0] IV_256 =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [255:0] IV_224 =
    256'hc1059ed8_367cd507_3070dd17_f70e5939_ffc00b31_68581511_64f98fa7_befa4fa4;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  function automatic logic [31:0] Sigma0(input logic [31:0] x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction

  function automatic logic [31:0] Sigma1(input logic [31:0] x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction

  function automatic logic [31:0] sigma0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] sigma1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

endpackage

// File: rtl/sha256_round.sv
// rtl/sha256_round.sv - one combinational SHA-256 compression round
// Working state is packed a..h from [255:224] down to [31:0].
module sha256_round
  import sha256_pkg::*;
(
  input  logic [255:0] st_i,
  input  logic [31:0]  k_i,
  input  logic [31:0]  w_i,
  output logic [255:0] st_o
);

  logic [31:0] a, b, c, d, e, f, g, h;
  logic [31:0] t1, t2;

  assign {a, b, c, d, e, f, g, h} = st_i;
  assign t1   = h + Sigma1(e) + ch(e, f, g) + k_i + w_i;
  assign t2   = Sigma0(a) + maj(a, b, c);
  assign st_o = {t1 + t2, a, b, c, d + t1, e, f, g};

endmodule

// File: rtl/sha256_stream.sv
// rtl/sha256_stream.sv - streaming SHA-256 over pre-padded 512-bit blocks
// Optional SHA256_SHA224_MODE_EN adds the mode224 port for SHA-224 results.
module sha256_stream
  import sha256_pkg::*;
#(
  parameter int IN_W        = 32,
  parameter int RND_PER_CLK = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [IN_W-1:0] in_data,
  input  logic            in_last,
`ifdef SHA256_SHA224_MODE_EN
  input  logic            mode224,
`endif
  output logic            digest_valid,
  input  logic            digest_ready,
  output logic [255:0]    digest
);

  localparam int         BEATS     = 512 / IN_W;
  localparam logic [3:0] LAST_BEAT = 4'(BEATS - 1);
  localparam logic [5:0] RND_STEP  = 6'(RND_PER_CLK);
  localparam logic [5:0] LAST_RND  = 6'(64 - RND_PER_CLK);

  state_e       state_q, state_d;
  logic [255:0] h_q, h_d;
  logic [255:0] wk_q, wk_d;
  logic [31:0]  w_q [16];
  logic [31:0]  w_d [16];
  logic [3:0]   beat_q, beat_d;
  logic [5:0]   rnd_q, rnd_d;
  logic         last_q, last_d;

  logic [255:0] iv_sel;
  logic [31:0]  beat_hi, beat_lo;
  logic [255:0] st_r0, st_r1;
  logic [31:0]  nw0, nw1;
  logic         shift_in, shift_rnd;

  if (IN_W == 64) begin : g_in64
    assign beat_hi = in_data[IN_W-1 -: 32];
    assign beat_lo = in_data[31:0];
  end else begin : g_in32
    assign beat_hi = '0;
    assign beat_lo = in_data[31:0];
  end

  // Schedule words W[t+16], W[t+17] from the window whose head is W[t].
  assign nw0 = sigma1(w_q[14]) + w_q[9]  + sigma0(w_q[1]) + w_q[0];
  assign nw1 = sigma1(w_q[15]) + w_q[10] + sigma0(w_q[2]) + w_q[1];

  sha256_round u_round0 (
    .st_i (wk_q),
    .k_i  (K[rnd_q]),
    .w_i  (w_q[0]),
    .st_o (st_r0)
  );

  if (RND_PER_CLK == 2) begin : g_rnd2
    sha256_round u_round1 (
      .st_i (st_r0),
      .k_i  (K[rnd_q + 6'd1]),
      .w_i  (w_q[1]),
      .st_o (st_r1)
    );
  end else begin : g_rnd1
    assign st_r1 = st_r0;
  end

`ifdef SHA256_SHA224_MODE_EN
  logic mode_q, mode_d;

  assign mode_d = (state_q == IDLE && in_valid) ? mode224 : mode_q;
  assign iv_sel = mode224 ? IV_224 : IV_256;
  assign digest = {h_q[255:32], mode_q ? 32'h0 : h_q[31:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) mode_q <= 1'b0;
    else     mode_q <= mode_d;
  end
`else
  assign iv_sel = IV_256;
  assign digest = h_q;
`endif

  always_comb begin
    state_d      = state_q;
    h_d          = h_q;
    wk_d         = wk_q;
    beat_d       = beat_q;
    rnd_d        = rnd_q;
    last_d       = last_q;
    in_ready     = 1'b0;
    digest_valid = 1'b0;
    shift_in     = 1'b0;
    shift_rnd    = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          shift_in = 1'b1;
          h_d      = iv_sel;
          beat_d   = 4'd1;
          last_d   = 1'b0;
          state_d  = LOAD;
        end
      end
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          shift_in = 1'b1;
          beat_d   = beat_q + 4'd1;
          if (beat_q == LAST_BEAT) begin
            last_d  = in_last;
            wk_d    = h_q;
            beat_d  = '0;
            rnd_d   = '0;
            state_d = ROUND;
          end
        end
      end
      ROUND: begin
        shift_rnd = 1'b1;
        wk_d      = st_r1;
        rnd_d     = rnd_q + RND_STEP;
        if (rnd_q == LAST_RND) state_d = ADD;
      end
      ADD: begin
        for (int i = 0; i < 8; i++) h_d[32*i +: 32] = h_q[32*i +: 32] + wk_q[32*i +: 32];
        state_d = last_q ? DONE : LOAD;
      end
      DONE: begin
        digest_valid = 1'b1;
        if (digest_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    w_d = w_q;
    if (shift_in) begin
      if (IN_W == 64) begin
        for (int i = 0; i < 14; i++) w_d[i] = w_q[i+2];
        w_d[14] = beat_hi;
        w_d[15] = beat_lo;
      end else begin
        for (int i = 0; i < 15; i++) w_d[i] = w_q[i+1];
        w_d[15] = beat_lo;
      end
    end else if (shift_rnd) begin
      if (RND_PER_CLK == 2) begin
        for (int i = 0; i < 14; i++) w_d[i] = w_q[i+2];
        w_d[14] = nw0;
        w_d[15] = nw1;
      end else begin
        for (int i = 0; i < 15; i++) w_d[i] = w_q[i+1];
        w_d[15] = nw0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      h_q     <= IV_256;
      wk_q    <= '0;
      beat_q  <= '0;
      rnd_q   <= '0;
      last_q  <= 1'b0;
      for (int i = 0; i < 16; i++) w_q[i] <= '0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      wk_q    <= wk_d;
      beat_q  <= beat_d;
      rnd_q   <= rnd_d;
      last_q  <= last_d;
      for (int i = 0; i < 16; i++) w_q[i] <= w_d[i];
    end
  end

endmodule

// File: tb/tb_sha256_stream.sv
// tb/tb_sha256_stream.sv - scoreboard bench for sha256_stream (32b/1-round and 64b/2-round instances)
// Defining SHA256_SHA224_MODE_EN adds the SHA-224 "abc" case.
module tb_sha256_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  localparam logic [255:0] IV256 = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] D_ABC = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] D_TWO = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
  localparam logic [255:0] D_224 = {224'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da7, 32'h0};

  logic        rst_a, in_valid_a, in_ready_a, in_last_a, dv_a, dr_a;
  logic [31:0] in_data_a;
  logic [255:0] digest_a;
  logic        rst_b, in_valid_b, in_ready_b, in_last_b, dv_b, dr_b;
  logic [63:0] in_data_b;
  logic [255:0] digest_b;
`ifdef SHA256_SHA224_MODE_EN
  logic        mode224_a, mode224_b;
`endif

  sha256_stream #(.IN_W(32), .RND_PER_CLK(1)) u_dut_a (
    .clk(clk), .rst(rst_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .in_data(in_data_a), .in_last(in_last_a),
`ifdef SHA256_SHA224_MODE_EN
    .mode224(mode224_a),
`endif
    .digest_valid(dv_a), .digest_ready(dr_a), .digest(digest_a)
  );

  sha256_stream #(.IN_W(64), .RND_PER_CLK(2)) u_dut_b (
    .clk(clk), .rst(rst_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_data(in_data_b), .in_last(in_last_b),
`ifdef SHA256_SHA224_MODE_EN
    .mode224(mode224_b),
`endif
    .digest_valid(dv_b), .digest_ready(dr_b), .digest(digest_b)
  );

  logic [31:0]  blk [3][16];
  logic [447:0] m2;

  logic [255:0] exp_dig_a [$];
  int           exp_lat_a [$];
  logic [255:0] exp_dig_b [$];
  int           exp_lat_b [$];
  int           last_cyc_a = 0;
  int           last_cyc_b = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input string what);
    total++;
    bad++;
    $display("FAIL %s: %s", name, what);
  endtask

  // Monitors: latency at digest_valid rise, hold stability and in_ready low while valid, digest at handshake.
  logic         prev_dv_a = 1'b0;
  logic         prev_dv_b = 1'b0;
  logic [255:0] hold_a, hold_b;

  always @(negedge clk) begin
    if (dv_a === 1'b1) begin
      if (!prev_dv_a) begin
        hold_a = digest_a;
        if (exp_lat_a.size() > 0) chk("latency_a", 256'(cyc - last_cyc_a), 256'(exp_lat_a.pop_front()));
        else fail_now("latency_a", "digest_valid rose with nothing expected");
      end else begin
        chk("hold_a", digest_a, hold_a);
      end
      chk("ready_low_done_a", 256'(in_ready_a), 256'(0));
      if (dr_a) begin
        if (exp_dig_a.size() > 0) chk("digest_a", digest_a, exp_dig_a.pop_front());
        else fail_now("digest_a", "unexpected handshake");
      end
    end
    prev_dv_a = dv_a;
  end

  always @(negedge clk) begin
    if (dv_b === 1'b1) begin
      if (!prev_dv_b) begin
        hold_b = digest_b;
        if (exp_lat_b.size() > 0) chk("latency_b", 256'(cyc - last_cyc_b), 256'(exp_lat_b.pop_front()));
        else fail_now("latency_b", "digest_valid rose with nothing expected");
      end else begin
        chk("hold_b", digest_b, hold_b);
      end
      chk("ready_low_done_b", 256'(in_ready_b), 256'(0));
      if (dr_b) begin
        if (exp_dig_b.size() > 0) chk("digest_b", digest_b, exp_dig_b.pop_front());
        else fail_now("digest_b", "unexpected handshake");
      end
    end
    prev_dv_b = dv_b;
  end

  task automatic wait_acc_a();
    bit acc = 1'b0;
    for (int n = 0; n < 300 && !acc; n++) begin
      @(negedge clk);
      acc = in_ready_a;
      @(posedge clk);
      #2;
    end
    if (!acc) fail_now("accept_a", "beat not accepted within 300 cycles");
  endtask

  task automatic wait_acc_b();
    bit acc = 1'b0;
    for (int n = 0; n < 300 && !acc; n++) begin
      @(negedge clk);
      acc = in_ready_b;
      @(posedge clk);
      #2;
    end
    if (!acc) fail_now("accept_b", "beat not accepted within 300 cycles");
  endtask

  task automatic send_a(input int bi, input bit last_flag, input bit gaps);
    for (int i = 0; i < 16; i++) begin
      if (gaps) begin
        in_valid_a = 1'b0;
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #2; end
      end
      in_valid_a = 1'b1;
      in_data_a  = blk[bi][i];
      in_last_a  = last_flag;
      wait_acc_a();
      if (i == 15) last_cyc_a = cyc;
    end
    in_valid_a = 1'b0;
    in_last_a  = 1'b0;
  endtask

  // in_last is raised on every non-final beat to show it is ignored there.
  task automatic send_b(input int bi, input bit last_flag);
    for (int i = 0; i < 8; i++) begin
      in_valid_b = 1'b1;
      in_data_b  = {blk[bi][2*i], blk[bi][2*i+1]};
      in_last_b  = (i == 7) ? last_flag : 1'b1;
      wait_acc_b();
      if (i == 7) last_cyc_b = cyc;
    end
    in_valid_b = 1'b0;
    in_last_b  = 1'b0;
  endtask

  task automatic wait_drain_a();
    for (int n = 0; n < 400 && exp_dig_a.size() > 0; n++) @(posedge clk);
    #2;
    if (exp_dig_a.size() > 0) fail_now("drain_a", "expected digest never delivered");
  endtask

  task automatic wait_drain_b();
    for (int n = 0; n < 400 && exp_dig_b.size() > 0; n++) @(posedge clk);
    #2;
    if (exp_dig_b.size() > 0) fail_now("drain_b", "expected digest never delivered");
  endtask

  task automatic ready_low_b(input string name, input int ncyc);
    int high = 0;
    for (int n = 0; n < ncyc; n++) begin
      @(negedge clk);
      if (in_ready_b) high++;
    end
    chk(name, 256'(high), 256'(0));
  endtask

  initial begin
    rst_a = 1'b1; in_valid_a = 1'b0; in_last_a = 1'b0; in_data_a = '0; dr_a = 1'b1;
    rst_b = 1'b1; in_valid_b = 1'b0; in_last_b = 1'b0; in_data_b = '0; dr_b = 1'b1;
`ifdef SHA256_SHA224_MODE_EN
    mode224_a = 1'b0; mode224_b = 1'b0;
`endif
    m2 = 448'h61626364_62636465_63646566_64656667_65666768_66676869_6768696a_68696a6b_696a6b6c_6a6b6c6d_6b6c6d6e_6c6d6e6f_6d6e6f70_6e6f7071;
    for (int b = 0; b < 3; b++) for (int i = 0; i < 16; i++) blk[b][i] = '0;
    blk[0][0]  = 32'h61626380;
    blk[0][15] = 32'h00000018;
    for (int i = 0; i < 14; i++) blk[1][i] = m2[447-32*i -: 32];
    blk[1][14] = 32'h80000000;
    blk[2][15] = 32'h000001c0;

    repeat (3) @(posedge clk);
    #2;
    rst_a = 1'b0;
    rst_b = 1'b0;
    @(negedge clk);
    chk("reset_ready_a", 256'(in_ready_a), 256'(1));
    chk("reset_valid_a", 256'(dv_a), 256'(0));
    chk("reset_iv_a", digest_a, IV256);
    chk("reset_ready_b", 256'(in_ready_b), 256'(1));
    chk("reset_valid_b", 256'(dv_b), 256'(0));
    chk("reset_iv_b", digest_b, IV256);
    @(posedge clk);
    #2;

    // "abc", back-to-back beats
    exp_dig_a.push_back(D_ABC); exp_lat_a.push_back(65);
    send_a(0, 1'b1, 1'b0);
    wait_drain_a();

    // "abc" with input gaps and the digest held for 10 cycles
    dr_a = 1'b0;
    exp_dig_a.push_back(D_ABC); exp_lat_a.push_back(65);
    send_a(0, 1'b1, 1'b1);
    begin
      bit seen = 1'b0;
      for (int n = 0; n < 200 && !seen; n++) begin @(negedge clk); seen = dv_a; end
      if (!seen) fail_now("hold_start_a", "digest_valid never rose");
    end
    repeat (10) begin @(posedge clk); #2; end
    dr_a = 1'b1;
    wait_drain_a();

    // abort at round 30, then a clean "abc"
    send_a(0, 1'b1, 1'b0);
    repeat (30) @(posedge clk);
    #2;
    rst_a = 1'b1;
    #2;
    chk("abort_ready_a", 256'(in_ready_a), 256'(1));
    chk("abort_valid_a", 256'(dv_a), 256'(0));
    chk("abort_iv_a", digest_a, IV256);
    @(posedge clk);
    #2;
    rst_a = 1'b0;
    exp_dig_a.push_back(D_ABC); exp_lat_a.push_back(65);
    send_a(0, 1'b1, 1'b0);
    wait_drain_a();

`ifdef SHA256_SHA224_MODE_EN
    mode224_a = 1'b1;
    exp_dig_a.push_back(D_224); exp_lat_a.push_back(65);
    send_a(0, 1'b1, 1'b0);
    mode224_a = 1'b0;
    wait_drain_a();
    exp_dig_a.push_back(D_ABC); exp_lat_a.push_back(65);
    send_a(0, 1'b1, 1'b0);
    wait_drain_a();
`endif

    // two-block message on the 64-bit, two-rounds-per-clock instance
    exp_dig_b.push_back(D_TWO); exp_lat_b.push_back(33);
    send_b(1, 1'b0);
    ready_low_b("ready_low_round1_b", 33);
    @(negedge clk);
    chk("ready_reload_b", 256'(in_ready_b), 256'(1));
    @(posedge clk);
    #2;
    send_b(2, 1'b1);
    ready_low_b("ready_low_round2_b", 33);
    wait_drain_b();

    chk("leftover_a", 256'(exp_dig_a.size()), 256'(0));
    chk("leftover_b", 256'(exp_dig_b.size()), 256'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sha256_stream.md
SHA256_STREAM -- requirements
Module: sha256_stream

Interface
REQ-001 Parameter IN_W, default 32, meaning input beat width in bits; legal values 32 and 64.
REQ-002 Parameter RND_PER_CLK, default 1, meaning compression rounds executed per clock; legal values 1 and 2.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  the input beat is valid.
REQ-006 in_ready  output  1  the block accepts a beat this cycle.
REQ-007 in_data  input  IN_W  message word(s); for IN_W=64, bits [63:32] are the earlier word.
REQ-008 in_last  input  1  the current 512-bit block is the final block of the message; sampled on the last beat of the block.
REQ-009 digest_valid  output  1  the digest is valid and held.
REQ-010 digest_ready  input  1  the consumer accepts the digest.
REQ-011 digest  output  256  H0 in [255:224] through H7 in [31:0].

Function
REQ-012 The input is pre-padded 512-bit blocks; the block performs no padding.
REQ-013 The FSM states are IDLE, LOAD, ROUND, ADD and DONE.
REQ-014 IDLE->LOAD occurs on the first accepted beat; H is initialised to the FIPS 180-4 IV when the message starts.
REQ-015 LOAD accepts 512/IN_W beats (16 or 8); each beat is a transfer with in_valid&&in_ready.
REQ-016 in_ready is 1 only in IDLE and LOAD.
REQ-017 After the final beat of a block, the block enters ROUND and stays there 64/RND_PER_CLK cycles; W[16..63] is computed on the fly from a 16-word shift window.
REQ-018 ADD lasts 1 cycle and computes H[i] += working[i], modulo 2^32 per word.
REQ-019 After ADD, if in_last was latched the block goes to DONE; otherwise it goes to LOAD with H kept (chaining).
REQ-020 DONE holds digest_valid=1 and a stable digest until digest_ready=1; the same cycle it returns to IDLE and drops digest_valid.
REQ-021 Latency from the last beat to digest_valid is 64/RND_PER_CLK+1 cycles.
REQ-022 Stalls (in_valid=0) during LOAD freeze the beat counter and the window; no timeout applies.
REQ-023 in_last on any beat other than the last beat of a block is ignored.
REQ-024 digest_ready while digest_valid=0 has no effect.
REQ-025 digest is combinationally driven from the H registers and is valid only while digest_valid=1.

Reset
REQ-026 Asserting rst in any state, including mid-LOAD or mid-ROUND, forces IDLE within the same cycle.
REQ-027 Reset clears the beat and round counters, sets in_ready=1 and digest_valid=0, loads H with the IV, and zeroes the working registers.
REQ-028 A partial message in progress at reset is discarded.

Configuration
REQ-029 With SHA256_SHA224_MODE_EN defined, the block adds an input port mode224 (1 bit), sampled at the first beat of a message.
REQ-030 When mode224=1, the block uses the SHA-224 IV and drives digest[31:0] to zero (a 224-bit result in [255:32]).
REQ-031 Without SHA256_SHA224_MODE_EN, the port is absent and the behaviour is SHA-256 only.

Structure
REQ-032 Package sha256_pkg holds: K[0..63] as a constant array, the SHA-256 and SHA-224 IV constants, the FSM state enum, and the functions ch, maj, Sigma0, Sigma1, sigma0 and sigma1.
REQ-033 One sub-module, sha256_round, implements a single combinational round; it is instantiated RND_PER_CLK times in a chain.

Verification
REQ-034 Single block "abc" padded, IN_W=32, RND_PER_CLK=1 -> digest ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad, with digest_valid exactly 65 cycles after the 16th beat.
REQ-035 Two-block NIST 448-bit message "abcdbcdecdefdefg…nopq", IN_W=64, RND_PER_CLK=2 -> digest 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1, with in_ready=0 during each 32-cycle ROUND phase.
REQ-036 Random in_valid gaps during LOAD plus digest_ready held 0 for 10 cycles -> the same "abc" digest, stable throughout the hold, and in_ready=0 until the handshake completes.
REQ-037 rst pulsed at round 30 of the first block, then "abc" sent -> the correct "abc" digest, with no residue from the aborted message.
REQ-038 SHA256_SHA224_MODE_EN with mode224=1 and "abc" -> digest[255:32] = 23097d22 3405d822 8642a477 bda255b3 2aadbce4 bda0b3f7 e36c9da7, and digest[31:0] = 0.
